// File: rtl/rr_stream_arbiter.sv
// Round-robin valid/ready arbiter with packet lock, feeding one registered output stage.
// One beat per cycle; the grant stays with a source from its first beat until its last beat.
module rr_stream_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          up_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   up_data,
  input  logic [NUM_REQ-1:0]          up_last,
  output logic [NUM_REQ-1:0]          up_ready,
  output logic                        down_valid,
  output logic [DATA_W-1:0]           down_data,
  output logic                        down_last,
  output logic [SRC_W-1:0]            down_src,
  input  logic                        down_ready
);

  logic              down_valid_q;
  logic [DATA_W-1:0] down_data_q;
  logic              down_last_q;
  logic [SRC_W-1:0]  down_src_q;
  logic              lock_q;
  logic [SRC_W-1:0]  lock_src_q;
  logic [SRC_W-1:0]  ptr_q;

  logic              load_en;
  logic              any_candidate;
  logic [SRC_W-1:0]  winner;
  logic [DATA_W-1:0] win_data;
  logic              win_last;

  assign load_en = down_ready | ~down_valid_q;

  // While locked only the lock owner's valid is consulted, so no other source
  // can influence the grant.
  always_comb begin
    logic             found;
    logic [SRC_W-1:0] cand;
    found         = 1'b0;
    cand          = '0;
    winner        = '0;
    any_candidate = 1'b0;
    if (lock_q) begin
      winner        = lock_src_q;
      any_candidate = up_valid[lock_src_q];
    end else begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        cand = SRC_W'((32'(ptr_q) + off) % NUM_REQ);
        if (!found && up_valid[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
      any_candidate = found;
    end
  end

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    up_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (winner == SRC_W'(i)) begin
        win_data    = up_data[i*DATA_W +: DATA_W];
        win_last    = up_last[i];
        up_ready[i] = load_en & any_candidate;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_last_q  <= 1'b0;
      down_src_q   <= '0;
      lock_q       <= 1'b0;
      lock_src_q   <= '0;
      ptr_q        <= SRC_W'(NUM_REQ - 1);
    end else if (load_en) begin
      down_valid_q <= any_candidate;
      if (any_candidate) begin
        down_data_q <= win_data;
        down_last_q <= win_last;
        down_src_q  <= winner;
        if (win_last) begin
          // Packet done: release and give the finishing source lowest priority.
          lock_q <= 1'b0;
          ptr_q  <= winner;
        end else begin
          lock_q     <= 1'b1;
          lock_src_q <= winner;
        end
      end
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_last  = down_last_q;
  assign down_src   = down_src_q;

endmodule
